// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and encodings for the memory arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT = 9;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_arb_sel.sv
// ============================================================================
// Module      : mem_arb_sel
// Description : Combinational winner select between cpu and dbg requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic       rr_ptr,
  output logic [1:0] winner
);

  // rr_ptr = 1 means dbg is preferred when both request.
  always_comb begin
    winner = OWN_NONE;
    if (cpu_req && !(dbg_req && rr_ptr)) begin
      winner = OWN_CPU;
    end else if (dbg_req) begin
      winner = OWN_DBG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (cpu/dbg) arbiter onto a single-port RAM with
//               1-cycle registered read. Optional macro MEM_ARB_RR_EN
//               enables round-robin resolution of simultaneous requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [1:0]        owner
);

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        w_winner;
  logic              w_rr_ptr;
  logic              w_start;
  logic              w_in_grant;
  logic              w_in_done;

  logic [1:0]        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  assign w_start = (r_state == ST_IDLE) && (cpu_req || dbg_req);

`ifdef MEM_ARB_RR_EN
  logic r_rr_ptr;

  // After each grant, prefer the port that did not win.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_start) begin
      r_rr_ptr <= (w_winner == OWN_CPU);
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = 1'b0;
`endif

  mem_arb_sel u_sel (
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .rr_ptr  (w_rr_ptr),
    .winner  (w_winner)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (cpu_req || dbg_req) w_next_state = ST_GRANT;
      ST_GRANT: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; later changes are ignored.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_owner     <= OWN_NONE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (w_start) begin
        r_owner <= w_winner;
        if (w_winner == OWN_CPU) begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end else begin
          r_we    <= dbg_we;
          r_addr  <= dbg_addr;
          r_wdata <= dbg_wdata;
        end
      end
      if ((r_state == ST_DONE) && !r_we) begin
        if (r_owner == OWN_CPU) begin
          r_cpu_rdata <= mem_rdata;
        end else if (r_owner == OWN_DBG) begin
          r_dbg_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Reset masks the strobes in the same cycle so an aborted access never acks.
  always_comb begin
    w_in_grant = (r_state == ST_GRANT) && !Reset;
    w_in_done  = (r_state == ST_DONE) && !Reset;
    mem_en     = w_in_grant;
    mem_we     = w_in_grant && r_we;
    owner      = (w_in_grant || w_in_done) ? r_owner : OWN_NONE;
    cpu_ack    = w_in_done && (r_owner == OWN_CPU);
    dbg_ack    = w_in_done && (r_owner == OWN_DBG);
    cpu_rdata  = (cpu_ack && !r_we) ? mem_rdata : r_cpu_rdata;
    dbg_rdata  = (dbg_ack && !r_we) ? mem_rdata : r_dbg_rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ram [0:511];
  logic [1:0]  exp_own;

  always #5 Clock = ~Clock;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  // Single-port RAM, registered read.
  always @(posedge Clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Full access from an IDLE cycle; ends in the following IDLE cycle.
  task automatic xfer(input string tag, input bit is_dbg, input bit we,
                      input logic [8:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd);
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    tick();
    check({tag, ".en"},    32'(mem_en), 32'd1);
    check({tag, ".we"},    32'(mem_we), 32'(we));
    check({tag, ".addr"},  32'(mem_addr), 32'(addr));
    if (we) check({tag, ".wdata"}, mem_wdata, wd);
    check({tag, ".own"},   32'(owner), is_dbg ? 32'd2 : 32'd1);
    tick();
    check({tag, ".ack"},   32'(is_dbg ? dbg_ack : cpu_ack), 32'd1);
    check({tag, ".ackx"},  32'(is_dbg ? cpu_ack : dbg_ack), 32'd0);
    check({tag, ".en0"},   32'(mem_en), 32'd0);
    check({tag, ".rd"},    is_dbg ? dbg_rdata : cpu_rdata, exp_rd);
    if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
    tick();
    check({tag, ".own0"},  32'(owner), 32'd0);
    check({tag, ".ack0"},  32'(is_dbg ? dbg_ack : cpu_ack), 32'd0);
    check({tag, ".rdh"},   is_dbg ? dbg_rdata : cpu_rdata, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = '0;

    // Reset state
    tick();
    tick();
    check("rst.en",    32'(mem_en), 32'd0);
    check("rst.we",    32'(mem_we), 32'd0);
    check("rst.ack",   32'({cpu_ack, dbg_ack}), 32'd0);
    check("rst.own",   32'(owner), 32'd0);
    check("rst.addr",  32'(mem_addr), 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.crd",   cpu_rdata, 32'd0);
    check("rst.drd",   dbg_rdata, 32'd0);
    Reset = 1'b0;
    tick();
    check("idle.en",   32'(mem_en), 32'd0);

    // Write then back-to-back read of 0x1F
    xfer("wr1f", 1'b0, 1'b1, 9'h01F, 32'hDEADBEEF, 32'h0);
    xfer("rd1f", 1'b0, 1'b0, 9'h01F, 32'h0, 32'hDEADBEEF);

    // Field change during GRANT is ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
    tick();
    cpu_addr = 9'h020;
    #1;
    check("latch.addr_g", 32'(mem_addr), 32'h010);
    tick();
    check("latch.addr_d", 32'(mem_addr), 32'h010);
    check("latch.ack",    32'(cpu_ack), 32'd1);
    check("latch.rd",     cpu_rdata, 32'h0);
    cpu_req = 1'b0;
    tick();

    // req dropped during GRANT still completes, once
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h01F;
    tick();
    cpu_req = 1'b0;
    check("drop.en",  32'(mem_en), 32'd1);
    tick();
    check("drop.ack", 32'(cpu_ack), 32'd1);
    check("drop.rd",  cpu_rdata, 32'hDEADBEEF);
    tick();
    check("drop.ack0", 32'(cpu_ack), 32'd0);
    check("drop.en0",  32'(mem_en), 32'd0);
    tick();
    check("drop.en1",  32'(mem_en), 32'd0);
    check("drop.own",  32'(owner), 32'd0);

    // Max address via dbg; dbg_rdata survives the write
    xfer("dbgrd",  1'b1, 1'b0, 9'h01F, 32'h0, 32'hDEADBEEF);
    xfer("dbgwr",  1'b1, 1'b1, 9'h1FF, 32'h00000001, 32'hDEADBEEF);
    xfer("cpurd",  1'b0, 1'b0, 9'h1FF, 32'h0, 32'h00000001);
    check("max.drd", dbg_rdata, 32'hDEADBEEF);

    // Simultaneous requests from a fresh reset
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h01F;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_own = i[0] ? 2'b10 : 2'b01;
`else
      exp_own = 2'b01;
`endif
      tick();
      check("arb.own", 32'(owner), 32'(exp_own));
      check("arb.en",  32'(mem_en), 32'd1);
      tick();
      check("arb.cack", 32'(cpu_ack), 32'(exp_own == 2'b01));
      check("arb.dack", 32'(dbg_ack), 32'(exp_own == 2'b10));
      tick();
      check("arb.own0", 32'(owner), 32'd0);
    end
    cpu_req = 1'b0;
    tick();
    check("arb.own_d", 32'(owner), 32'd2);
    tick();
    check("arb.dack_d", 32'(dbg_ack), 32'd1);
    check("arb.cack_d", 32'(cpu_ack), 32'd0);
    check("arb.drd",    dbg_rdata, 32'h00000001);
    check("arb.crd",    cpu_rdata, 32'hDEADBEEF);
    dbg_req = 1'b0;
    tick();

    // Reset during DONE aborts the dbg read
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h000;
    tick();
    check("abort.own_g", 32'(owner), 32'd2);
    tick();
    Reset = 1'b1;
    dbg_req = 1'b0;
    #1;
    check("abort.ack", 32'(dbg_ack), 32'd0);
    tick();
    check("abort.ack1", 32'(dbg_ack), 32'd0);
    check("abort.own",  32'(owner), 32'd0);
    check("abort.en",   32'(mem_en), 32'd0);
    check("abort.drd",  dbg_rdata, 32'd0);
    Reset = 1'b0;
    tick();
    check("abort.idle", 32'(mem_en), 32'd0);
    xfer("post", 1'b0, 1'b0, 9'h1FF, 32'h0, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter: ADDR_W, 9, memory word-address width.
REQ-002 SHALL provide parameter: DATA_W, 32, memory data width.
REQ-003 SHALL provide port: Clock  in  1  system clock; all state changes on rising edge.
REQ-004 SHALL provide port: Reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL provide ports: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W; these form the control-unit access request (MAR/MDR side).
REQ-006 SHALL provide ports: cpu_ack out 1 (one-cycle completion pulse) and cpu_rdata out DATA_W (read data).
REQ-007 SHALL provide ports: dbg_req in 1, dbg_we in 1, dbg_addr in ADDR_W, dbg_wdata in DATA_W; these form the debug/program-loader request.
REQ-008 SHALL provide ports: dbg_ack out 1 and dbg_rdata out DATA_W.
REQ-009 SHALL provide ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W; this is the single-port RAM with 1-cycle registered read.
REQ-010 SHALL provide port: owner out 2; 00 = none, 01 = cpu, 10 = dbg; the current grant holder.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, DONE; GRANT always goes to DONE, and DONE always goes to IDLE.
REQ-012 In IDLE, when any req is sampled high, SHALL select a winner, latch its we/addr/wdata, and go to GRANT; otherwise it stays in IDLE.
REQ-013 In GRANT, SHALL drive mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, for exactly one cycle.
REQ-014 In DONE, SHALL pulse the winner's ack for one cycle; on a read, the winner's rdata SHALL equal mem_rdata during and after that cycle.
REQ-015 Latency: req sampled at edge N -> mem_en high in cycle N+1 -> ack high in cycle N+2. Throughput is one access per 3 cycles.
REQ-016 Each rdata register SHALL hold its value until that port's next read completes; writes SHALL NOT alter rdata.
REQ-017 Requesters SHALL hold req and fields stable until ack, then deassert on the edge that samples ack. A req still high in the following IDLE cycle is a new request.
REQ-018 Simultaneous requests without macro: cpu wins.
REQ-019 A req dropped before ack SHALL NOT abort the access; the access completes and ack still pulses.
REQ-020 Changing request fields after IDLE SHALL have no effect, since the values are latched at IDLE.
REQ-021 The losing requester SHALL stay pending, with no ack, until it wins a later IDLE evaluation.
REQ-022 owner SHALL be nonzero only in GRANT and DONE.
REQ-023 Outside GRANT, mem_en and mem_we SHALL be 0.

Reset
REQ-024 Reset SHALL force: state IDLE; mem_en, mem_we, cpu_ack, dbg_ack = 0; owner = 00; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0; round-robin pointer = cpu-next.
REQ-025 Reset asserted in GRANT or DONE SHALL abort the access: no ack is issued, and mem_en is 0 from the next cycle.
REQ-026 Reset SHALL take priority over every other event.

Configuration
REQ-027 Macro MEM_ARB_RR_EN: when defined, simultaneous requests SHALL be resolved round-robin. A 1-bit pointer names the preferred port; it is updated to the non-winner on every grant.
REQ-028 Without MEM_ARB_RR_EN: fixed cpu priority and no pointer register.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the FSM state enum, the owner encodings (OWN_NONE/OWN_CPU/OWN_DBG), and the ADDR_W/DATA_W defaults.
REQ-030 A single sub-module mem_arb_sel is natural: a combinational winner select from cpu_req, dbg_req and the pointer. Without the macro, its pointer input is tied to cpu-next.

Verification
REQ-031 cpu write 0x1F, data 0xDEADBEEF, then cpu read 0x1F -> mem_en pulses in cycles N+1 and N+4, and cpu_rdata=0xDEADBEEF with cpu_ack in cycle N+5.
REQ-032 cpu_req and dbg_req both high in the same IDLE cycle, held repeatedly -> without macro, cpu_ack first, dbg waits until cpu drops. With MEM_ARB_RR_EN, grants alternate cpu, dbg, cpu, dbg.
REQ-033 dbg read 0x000 in flight, Reset high in DONE -> dbg_ack stays 0, owner=00, state IDLE next cycle.
REQ-034 cpu_addr changed from 0x010 to 0x020 during GRANT -> mem_addr stays 0x010.
REQ-035 dbg write 0x1FF (max address), data 0x00000001, then cpu read 0x1FF -> cpu_rdata=0x00000001, and dbg_rdata is unchanged from its prior read.
REQ-036 cpu_req dropped in GRANT cycle -> access completes, cpu_ack pulses once, FSM returns to IDLE, no second mem_en.
